// File: rtl/clkrst_supervisor.sv
// Run supervisor: sequences core reset from the board reset, counts run cycles
// against a limit, and halts the core with a sticky status on error/timeout/done.
module clkrst_supervisor #(
  parameter int SYNC_STAGES = 2,
  parameter int RST_CYCLES  = 2,
  parameter int CNT_W       = 32,
  parameter int MAX_CYCLES  = 100,
  parameter int NUM_ERR     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_ERR-1:0] err,
  input  logic               done_i,
  input  logic               clr_i,
  output logic               core_rst,
  output logic               run,
  output logic               halted,
  output logic [1:0]         status,
  output logic [NUM_ERR-1:0] err_src,
  output logic [CNT_W-1:0]   cycle_count
);

  typedef enum logic [2:0] {
    S_RESET,
    S_RUN,
    S_HALT_ERR,
    S_HALT_TO,
    S_HALT_DONE
  } state_t;

  localparam int              RC_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MAX_CYCLES - 1);
  localparam bit              TO_EN   = (MAX_CYCLES != 0);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rst_sync;
  state_t                 state_q, state_d;
  logic [RC_W-1:0]        rc_q, rc_d;
  logic [CNT_W-1:0]       cnt_d;
  logic [NUM_ERR-1:0]     err_src_d;

  // Assertion clears the chain at once; release ripples through SYNC_STAGES flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  assign rst_sync = sync_q[SYNC_STAGES-1];

  // NOTE: every variable assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    rc_d      = rc_q;
    cnt_d     = cycle_count;
    err_src_d = err_src;
    unique case (state_q)
      S_RESET: begin
        if (clr_i) begin
          rc_d = RC_LOAD;
        end else if (rst_sync) begin
          if (rc_q == '0) state_d = S_RUN;
          else            rc_d    = rc_q - RC_W'(1);
        end
      end
      S_RUN: begin
        if (clr_i) begin
          state_d   = S_RESET;
          rc_d      = RC_LOAD;
          cnt_d     = '0;
          err_src_d = '0;
        end else begin
          if (cycle_count != '1) cnt_d = cycle_count + CNT_W'(1);
          // Exit priority: error, then timeout, then completion.
          if (|err) begin
            state_d   = S_HALT_ERR;
            err_src_d = err;
          end else if (TO_EN && cycle_count == TO_LAST) begin
            state_d = S_HALT_TO;
          end else if (done_i) begin
            state_d = S_HALT_DONE;
          end
        end
      end
      default: begin
        if (clr_i) begin
          state_d   = S_RESET;
          rc_d      = RC_LOAD;
          cnt_d     = '0;
          err_src_d = '0;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RESET;
      rc_q        <= RC_LOAD;
      cycle_count <= '0;
      err_src     <= '0;
    end else begin
      state_q     <= state_d;
      rc_q        <= rc_d;
      cycle_count <= cnt_d;
      err_src     <= err_src_d;
    end
  end

  // Outputs decode the state register only, so no input reaches an output combinationally.
  always_comb begin
    core_rst = 1'b0;
    run      = 1'b0;
    halted   = 1'b0;
    status   = 2'b00;
    unique case (state_q)
      S_RESET:     core_rst = 1'b1;
      S_RUN:       run      = 1'b1;
      S_HALT_ERR:  begin halted = 1'b1; status = 2'b01; end
      S_HALT_TO:   begin halted = 1'b1; status = 2'b10; end
      S_HALT_DONE: begin halted = 1'b1; status = 2'b11; end
      default:     core_rst = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_clkrst_supervisor.sv
// Self-checking bench: two supervisor instances (timeout at 20; 4-bit counter with
// timeout disabled) checked every cycle against a behavioural model plus literal checks.
module tb_clkrst_supervisor;

  localparam int SYNC = 2;
  localparam int RSTC = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clr = 1'b0;
  logic [3:0] err_a = '0, err_b = '0;
  logic       done_a = 1'b0, done_b = 1'b0;

  logic        cr_a, run_a, hl_a, cr_b, run_b, hl_b;
  logic [1:0]  st_a, st_b;
  logic [3:0]  es_a, es_b;
  logic [31:0] cc_a;
  logic [3:0]  cc_b;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  clkrst_supervisor #(.SYNC_STAGES(SYNC), .RST_CYCLES(RSTC), .CNT_W(32),
                      .MAX_CYCLES(20), .NUM_ERR(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .err(err_a), .done_i(done_a), .clr_i(clr),
    .core_rst(cr_a), .run(run_a), .halted(hl_a), .status(st_a),
    .err_src(es_a), .cycle_count(cc_a));

  clkrst_supervisor #(.SYNC_STAGES(SYNC), .RST_CYCLES(RSTC), .CNT_W(4),
                      .MAX_CYCLES(0), .NUM_ERR(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .err(err_b), .done_i(done_b), .clr_i(clr),
    .core_rst(cr_b), .run(run_b), .halted(hl_b), .status(st_b),
    .err_src(es_b), .cycle_count(cc_b));

  // Model: "in reset" until SYNC release edges plus RSTC counted edges have passed;
  // afterwards either running or halted with a frozen cause.
  typedef struct {
    bit         in_reset;
    bit         halted;
    bit [1:0]   status;
    bit [3:0]   err_src;
    longint     cnt;
    int         sync_e;
    int         rst_e;
  } model_t;

  function automatic model_t m_reset();
    model_t m;
    m.in_reset = 1'b1;
    m.halted   = 1'b0;
    m.status   = 2'd0;
    m.err_src  = 4'd0;
    m.cnt      = 0;
    m.sync_e   = 0;
    m.rst_e    = 0;
    return m;
  endfunction

  function automatic model_t m_step(model_t m, bit c, bit [3:0] e, bit d,
                                    longint maxc, longint maxv);
    model_t n = m;
    if (m.in_reset) begin
      if (m.sync_e < SYNC) n.sync_e = m.sync_e + 1;
      else if (c) n.rst_e = 0;
      else begin
        n.rst_e = m.rst_e + 1;
        if (n.rst_e == RSTC) n.in_reset = 1'b0;
      end
    end else if (c) begin
      n = m_reset();
      n.sync_e = SYNC;
    end else if (!m.halted) begin
      n.cnt = (m.cnt < maxv) ? m.cnt + 1 : maxv;
      if (e != 0) begin
        n.halted = 1'b1; n.status = 2'd1; n.err_src = e;
      end else if (maxc != 0 && m.cnt == maxc - 1) begin
        n.halted = 1'b1; n.status = 2'd2;
      end else if (d) begin
        n.halted = 1'b1; n.status = 2'd3;
      end
    end
    return n;
  endfunction

  model_t ma, mb;

  initial begin
    ma = m_reset();
    mb = m_reset();
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma = m_reset();
      mb = m_reset();
    end else begin
      ma = m_step(ma, clr, err_a, done_a, 20, 64'hFFFF_FFFF);
      mb = m_step(mb, clr, err_b, done_b, 0, 15);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic cmp_dut(input string tag, input model_t m, input logic cr, input logic rn,
                         input logic hl, input logic [1:0] st, input logic [3:0] es,
                         input logic [31:0] cc);
    check({tag, ".core_rst"}, 32'(cr), 32'(m.in_reset));
    check({tag, ".run"}, 32'(rn), 32'(!m.in_reset && !m.halted));
    check({tag, ".halted"}, 32'(hl), 32'(m.halted));
    check({tag, ".status"}, 32'(st), 32'(m.status));
    check({tag, ".err_src"}, 32'(es), 32'(m.err_src));
    check({tag, ".cycle_count"}, cc, 32'(m.cnt));
  endtask

  always @(negedge clk) begin
    cmp_dut("A", ma, cr_a, run_a, hl_a, st_a, es_a, cc_a);
    cmp_dut("B", mb, cr_b, run_b, hl_b, st_b, es_b, {28'd0, cc_b});
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    step(2);
    check("reset.core_rst", 32'(cr_a), 32'd1);
    check("reset.run", 32'(run_a), 32'd0);
    check("reset.cycle_count", cc_a, 32'd0);

    // Release mid-cycle: core_rst falls on the 4th rising edge.
    rst_n = 1'b1;
    step(3);
    check("release.core_rst_e3", 32'(cr_a), 32'd1);
    step(1);
    check("release.core_rst_e4", 32'(cr_a), 32'd0);
    check("release.run_e4", 32'(run_a), 32'd1);
    check("release.count0", cc_a, 32'd0);

    // Timeout at 20 RUN edges, then frozen.
    step(19);
    check("timeout.not_yet", 32'(hl_a), 32'd0);
    step(1);
    check("timeout.halted", 32'(hl_a), 32'd1);
    check("timeout.status", 32'(st_a), 32'd2);
    check("timeout.count", cc_a, 32'd20);
    step(10);
    check("timeout.frozen", cc_a, 32'd20);

    // Restart, then simultaneous error and done at RUN cycle 5.
    clr = 1'b1; step(1); clr = 1'b0;
    check("restart_to.core_rst", 32'(cr_a), 32'd1);
    step(2);
    check("restart_to.run", 32'(run_a), 32'd1);
    step(5);
    check("prio.count5", cc_a, 32'd5);
    err_a = 4'b1010; done_a = 1'b1;
    step(1);
    err_a = 4'b0001; done_a = 1'b0;
    check("prio.status", 32'(st_a), 32'd1);
    check("prio.err_src", 32'(es_a), 32'h0000_000a);
    check("prio.count", cc_a, 32'd6);
    step(1);
    err_a = 4'b0000;
    check("prio.err_src_frozen", 32'(es_a), 32'h0000_000a);

    // Done halt, then restart from HALT_DONE.
    clr = 1'b1; step(1); clr = 1'b0;
    step(2);
    step(3);
    done_a = 1'b1; step(1); done_a = 1'b0;
    check("done.status", 32'(st_a), 32'd3);
    check("done.count", cc_a, 32'd4);
    step(1);
    clr = 1'b1; step(1); clr = 1'b0;
    check("restart.core_rst", 32'(cr_a), 32'd1);
    check("restart.halted", 32'(hl_a), 32'd0);
    check("restart.status", 32'(st_a), 32'd0);
    step(1);
    check("restart.core_rst_e1", 32'(cr_a), 32'd1);
    step(1);
    check("restart.core_rst_e2", 32'(cr_a), 32'd0);
    check("restart.count0", cc_a, 32'd0);

    // Asynchronous reset between edges at cycle_count 7.
    step(7);
    check("async.count7", cc_a, 32'd7);
    #2 rst_n = 1'b0;
    #1;
    check("async.core_rst", 32'(cr_a), 32'd1);
    check("async.run", 32'(run_a), 32'd0);
    check("async.count", cc_a, 32'd0);
    check("async.status", 32'(st_a), 32'd0);
    step(2);
    rst_n = 1'b1;

    // 4-bit counter with the timeout disabled saturates and stays in RUN.
    step(4);
    step(40);
    check("sat.count", {28'd0, cc_b}, 32'd15);
    check("sat.run", 32'(run_b), 32'd1);
    check("sat.halted", 32'(hl_b), 32'd0);

    // Randomized phase checked by the model.
    for (int i = 0; i < 3000; i++) begin
      step(1);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        step($urandom_range(1, 3));
        rst_n = 1'b1;
      end
      err_a  = ($urandom_range(0, 24) == 0) ? 4'($urandom) : 4'd0;
      err_b  = ($urandom_range(0, 24) == 0) ? 4'($urandom) : 4'd0;
      done_a = ($urandom_range(0, 29) == 0);
      done_b = ($urandom_range(0, 29) == 0);
      clr    = ($urandom_range(0, 59) == 0);
    end
    err_a = '0; err_b = '0; done_a = 1'b0; done_b = 1'b0; clr = 1'b0;
    step(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
